mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the CPU datapath. Accepts the CPU's address, write data and rd/wr strobes.
//  Runs one access per request on a synchronous memory bus with wait states and a ready handshake.
//  Returns read data, and holds the CPU controller off with cpu_stall until the access completes.
//  Bounds each access with a timeout; a timed-out access completes as a bus error.
// PARAMETERS
//  ADDR_W       16  address width (matches CPU address bus A)
//  DATA_W       16  data width
//  WAIT_STATES  1   minimum ACCESS cycles before mem_ready is honoured
//  TIMEOUT      15  cnt value at which an unfinished access aborts; TIMEOUT >= WAIT_STATES
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  cpu_addr   in   ADDR_W  access address
//  cpu_wdata  in   DATA_W  write data
//  cpu_rd     in   1       read request (level)
//  cpu_wr     in   1       write request (level)
//  cpu_rdata  out  DATA_W  registered read data; valid while cpu_done=1
//  cpu_stall  out  1       controller must hold its state while high
//  cpu_done   out  1       one-cycle completion pulse
//  cpu_err    out  1       qualifies cpu_done: timeout or illegal request
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched write data
//  mem_ce     out  1       bus cycle active
//  mem_we     out  1       write cycle (valid only with mem_ce)
//  mem_rdata  in   DATA_W  memory read data
//  mem_ready  in   1       memory completion
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0. All outputs are 0 after the first rst edge: cpu_rdata, cpu_done, cpu_err, cpu_stall, mem_*.
//  - rst mid-access aborts at that edge. No cpu_done is issued.
//  - FSM states: IDLE, ACCESS, DONE, RELEASE.
//  - IDLE, request = cpu_rd^cpu_wr: latch addr, wdata and op; go to ACCESS with cnt=0.
//  - IDLE, cpu_rd&cpu_wr (illegal): no bus cycle; go to DONE with err=1 and rdata=16'hFFFF.
//  - ACCESS: mem_ce=1, mem_we=op_wr. Address and data are held stable. cnt increments each cycle.
//    - Complete when cnt>=WAIT_STATES && mem_ready. Capture mem_rdata (reads only; writes leave rdata unchanged). Go to DONE.
//    - Else if cnt==TIMEOUT: go to DONE with err=1 and rdata=16'hFFFF.
//    - mem_ready before WAIT_STATES is ignored.
//  - DONE, exactly 1 cycle: cpu_done=1, mem_ce=0. cpu_err is valid.
//    - If cpu_rd|cpu_wr is still high, go to RELEASE; else go to IDLE.
//  - RELEASE: wait for cpu_rd=cpu_wr=0, then go to IDLE. A held strobe never starts a second access.
//  - cpu_stall (combinational) = ACCESS | (IDLE & (cpu_rd|cpu_wr)). It is 0 in DONE and RELEASE.
//  - Latency: request in IDLE at cycle 0 with ready already high gives cpu_done at cycle 2+WAIT_STATES.
//  - Timeout: cpu_done at cycle 2+TIMEOUT.
//  - cnt is $clog2(TIMEOUT+1) bits wide and never wraps; it saturates at TIMEOUT.
//  - cpu_err is 0 whenever cpu_done is 0.
// STRUCTURE
//  - Shared package cpu_pkg holds ADDR_W/DATA_W defaults, the bus-state enum (IDLE/ACCESS/DONE/RELEASE) and BUS_ERR_DATA=16'hFFFF.
//  - One sub-module, bus_wait_timer: clear, enable, saturating cnt, min_met (cnt>=WAIT_STATES) and expired (cnt==TIMEOUT).
//  - FSM, latches and output registers stay in mem_bus_ctrl.
// TESTING
//  - Read, W=1, ready tied high, addr 16'h0040, mem_rdata 16'h1234:
//    mem_ce in cycles 1-2; cpu_done at cycle 3 with rdata 16'h1234 and err=0; stall high in cycles 0-2.
//  - Write to 16'h0100 of 16'hBEEF, ready asserted 4 cycles late:
//    mem_we/mem_ce held with addr/data stable throughout; cpu_done the cycle after ready is sampled; cpu_rdata unchanged.
//  - Timeout, ready held low, TIMEOUT=15: cpu_done and cpu_err at cycle 17, rdata 16'hFFFF, mem_ce low in DONE.
//  - rd&wr together: mem_ce never rises; cpu_done and cpu_err at cycle 1, rdata 16'hFFFF.
//  - rd held high 3 cycles past done: no second mem_ce. After rd falls and rises again, a new access starts.
//  - rst pulsed in the 2nd ACCESS cycle: next edge mem_ce=0 and stall=0; no cpu_done pulse; next read completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side memory bus stage.
//   - default address/data widths
//   - bus controller state encoding
//   - data returned on a failed access
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_DATA_W = 16;

  // Read data returned with cpu_err (timeout or illegal request).
  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StDone    = 2'd2,
    StRelease = 2'd3
  } bus_state_e;

  // A legal request is exactly one of rd/wr.
  function automatic logic is_single_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state / timeout counter for one bus access.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   clear_i    force count to zero (has priority over en_i)
//   en_i       count one access cycle
//   min_met_o  count has reached the minimum wait-state count
//   expired_o  count has reached the timeout value
module bus_wait_timer #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic min_met_o,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT_STATES);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Saturates at TIMEOUT so a stuck access can never wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign min_met_o = (cnt_q >= WaitCnt);
  assign expired_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller sitting after the CPU datapath. Runs one bus access per CPU
// request with wait states, a ready handshake and a timeout, and stalls the CPU meanwhile.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cpu_addr, cpu_wdata      CPU access address / write data
//   cpu_rd, cpu_wr           CPU request strobes (level)
//   cpu_rdata                registered read data, valid with cpu_done
//   cpu_stall                CPU must hold its state while high
//   cpu_done, cpu_err        one-cycle completion pulse and its error qualifier
//   mem_addr, mem_wdata      latched bus address / write data
//   mem_ce, mem_we           bus cycle active / write cycle
//   mem_rdata, mem_ready     memory read data / completion
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = CPU_ADDR_W,
  parameter int unsigned DATA_W      = CPU_DATA_W,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [DATA_W-1:0] ErrData = DATA_W'(BUS_ERR_DATA);

  bus_state_e        state_d, state_q;
  logic              op_wr_d, op_wr_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              done_d, done_q;
  logic              err_d, err_q;
  logic              ce_d, ce_q;
  logic              we_d, we_q;

  logic              min_met;
  logic              expired;
  logic              any_req;

  assign any_req = cpu_rd | cpu_wr;

  // Counter runs only while a bus cycle is in flight and restarts from zero otherwise.
  bus_wait_timer #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (state_q != StAccess),
    .en_i     (state_q == StAccess),
    .min_met_o(min_met),
    .expired_o(expired)
  );

  // Next-state and registered-output computation. Bus/completion outputs are derived from
  // the state being entered, so they line up exactly with the registered state.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ce_d    = 1'b0;
    we_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_single_req(cpu_rd, cpu_wr)) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          op_wr_d = cpu_wr;
          state_d = StAccess;
          ce_d    = 1'b1;
          we_d    = cpu_wr;
        end else if (cpu_rd && cpu_wr) begin
          // Illegal request: answer with an error without touching the bus.
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ErrData;
        end
      end

      StAccess: begin
        // Completion is checked before the timeout so a ready on the last cycle still wins.
        if (min_met && mem_ready) begin
          state_d = StDone;
          done_d  = 1'b1;
          if (!op_wr_q) begin
            rdata_d = mem_rdata;
          end
        end else if (expired) begin
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ErrData;
        end else begin
          ce_d = 1'b1;
          we_d = op_wr_q;
        end
      end

      StDone: begin
        state_d = any_req ? StRelease : StIdle;
      end

      StRelease: begin
        // A strobe still held from the finished access must not start another one.
        if (!any_req) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ce    = ce_q;
  assign mem_we    = we_q;

  // Stall is combinational so the CPU is held in the same cycle it raises a request.
  assign cpu_stall = (state_q == StAccess) || ((state_q == StIdle) && any_req);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .WAIT_STATES(1),
    .TIMEOUT    (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_done (cpu_done),
    .cpu_err  (cpu_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ce", mem_ce, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Read, ready tied high: ce in cycles 1-2, done in cycle 3
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    cpu_addr  = 16'h0040;
    cpu_rd    = 1'b1;
    #1;
    chk("rd_c0_stall", cpu_stall, 1);
    chk("rd_c0_ce", mem_ce, 0);
    tick();
    chk("rd_c1_ce", mem_ce, 1);
    chk("rd_c1_we", mem_we, 0);
    chk("rd_c1_addr", mem_addr, 16'h0040);
    chk("rd_c1_stall", cpu_stall, 1);
    chk("rd_c1_done", cpu_done, 0);
    tick();
    chk("rd_c2_ce", mem_ce, 1);
    chk("rd_c2_stall", cpu_stall, 1);
    chk("rd_c2_done", cpu_done, 0);
    cpu_rd = 1'b0;
    tick();
    chk("rd_c3_done", cpu_done, 1);
    chk("rd_c3_err", cpu_err, 0);
    chk("rd_c3_rdata", cpu_rdata, 16'h1234);
    chk("rd_c3_ce", mem_ce, 0);
    chk("rd_c3_stall", cpu_stall, 0);
    tick();
    chk("rd_c4_done", cpu_done, 0);
    chk("rd_c4_rdata_hold", cpu_rdata, 16'h1234);

    // Write, ready raised late; CPU-side inputs change but bus side stays latched
    mem_ready = 1'b0;
    mem_rdata = 16'h5555;
    cpu_addr  = 16'h0100;
    cpu_wdata = 16'hBEEF;
    cpu_wr    = 1'b1;
    tick();
    cpu_addr  = 16'hDEAD;
    cpu_wdata = 16'hDEAD;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("wr_c%0d_ce", c), mem_ce, 1);
      chk($sformatf("wr_c%0d_we", c), mem_we, 1);
      chk($sformatf("wr_c%0d_addr", c), mem_addr, 16'h0100);
      chk($sformatf("wr_c%0d_wdata", c), mem_wdata, 16'hBEEF);
      chk($sformatf("wr_c%0d_done", c), cpu_done, 0);
      if (c == 6) begin
        mem_ready = 1'b1;
        cpu_wr    = 1'b0;
      end else begin
        tick();
      end
    end
    tick();
    chk("wr_done", cpu_done, 1);
    chk("wr_err", cpu_err, 0);
    chk("wr_rdata_unchanged", cpu_rdata, 16'h1234);
    chk("wr_done_ce", mem_ce, 0);
    mem_ready = 1'b0;
    tick();
    chk("wr_after_done", cpu_done, 0);

    // Illegal rd&wr: no bus cycle, error at cycle 1
    cpu_rd = 1'b1;
    cpu_wr = 1'b1;
    #1;
    chk("ill_c0_stall", cpu_stall, 1);
    tick();
    chk("ill_c1_ce", mem_ce, 0);
    chk("ill_c1_done", cpu_done, 1);
    chk("ill_c1_err", cpu_err, 1);
    chk("ill_c1_rdata", cpu_rdata, 16'hFFFF);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    tick();
    chk("ill_c2_ce", mem_ce, 0);
    chk("ill_c2_done", cpu_done, 0);
    chk("ill_c2_err", cpu_err, 0);

    // Held read strobe: no second access until it drops and rises again
    mem_ready = 1'b1;
    mem_rdata = 16'h00A5;
    cpu_addr  = 16'h0300;
    cpu_rd    = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_c3_done", cpu_done, 1);
    chk("hold_c3_rdata", cpu_rdata, 16'h00A5);
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk($sformatf("hold_c%0d_ce", c), mem_ce, 0);
      chk($sformatf("hold_c%0d_done", c), cpu_done, 0);
      chk($sformatf("hold_c%0d_stall", c), cpu_stall, 0);
    end
    tick();
    cpu_rd = 1'b0;
    tick();
    chk("hold_c8_ce", mem_ce, 0);
    mem_rdata = 16'h00B6;
    cpu_rd    = 1'b1;
    #1;
    chk("hold_c8_stall", cpu_stall, 1);
    tick();
    chk("hold_c9_ce", mem_ce, 1);
    tick();
    cpu_rd = 1'b0;
    tick();
    chk("hold_c11_done", cpu_done, 1);
    chk("hold_c11_rdata", cpu_rdata, 16'h00B6);
    tick();

    // Timeout with ready held low: done+err at cycle 17
    mem_ready = 1'b0;
    mem_rdata = 16'h7777;
    cpu_addr  = 16'h0200;
    cpu_rd    = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("to_c%0d_ce", c), mem_ce, 1);
      chk($sformatf("to_c%0d_done", c), cpu_done, 0);
    end
    cpu_rd = 1'b0;
    tick();
    chk("to_c17_done", cpu_done, 1);
    chk("to_c17_err", cpu_err, 1);
    chk("to_c17_rdata", cpu_rdata, 16'hFFFF);
    chk("to_c17_ce", mem_ce, 0);
    tick();
    chk("to_c18_done", cpu_done, 0);
    chk("to_c18_err", cpu_err, 0);

    // Reset in the 2nd access cycle aborts without a done pulse
    cpu_addr = 16'h0400;
    cpu_rd   = 1'b1;
    tick();
    tick();
    chk("rst_mid_ce_before", mem_ce, 1);
    rst    = 1'b1;
    cpu_rd = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_ce", mem_ce, 0);
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_done", cpu_done, 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    tick();
    chk("rst_mid_no_done", cpu_done, 0);
    mem_ready = 1'b1;
    mem_rdata = 16'h0C0C;
    cpu_addr  = 16'h0500;
    cpu_rd    = 1'b1;
    tick();
    chk("post_rst_ce", mem_ce, 1);
    chk("post_rst_addr", mem_addr, 16'h0500);
    tick();
    cpu_rd = 1'b0;
    tick();
    chk("post_rst_done", cpu_done, 1);
    chk("post_rst_err", cpu_err, 0);
    chk("post_rst_rdata", cpu_rdata, 16'h0C0C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
